// File: rtl/button_pkg.sv
// Shared button-path definitions: FSM state encoding and default timing constants
// used by the debouncer, the press classifier and the counter/LED blocks.
package button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } press_state_t;

    // 100 ms ticks at 25 MHz
    localparam int DEF_TICK_DIV        = 2_500_000;
    localparam int DEF_TICK_W          = 4;
    localparam int DEF_SHORT_MAX_TICKS = 3;
    localparam int DEF_LONG_MIN_TICKS  = 12;
    localparam int DEF_REPEAT_TICKS    = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-TICK_DIV prescaler with synchronous clear; tick is high on the wrap cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign tick = ~clr & (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (clr || tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Times debounced button presses in prescaled ticks and emits one-cycle
// short/mid/long classification pulses plus auto-repeat while a long press is held.
module press_classifier
    import button_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int TICK_W          = DEF_TICK_W,
    parameter int SHORT_MAX_TICKS = DEF_SHORT_MAX_TICKS,
    parameter int LONG_MIN_TICKS  = DEF_LONG_MIN_TICKS,
    parameter int REPEAT_TICKS    = DEF_REPEAT_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pb_state,
    input  logic              pb_down,
    input  logic              pb_up,
    output logic              short_press,
    output logic              mid_press,
    output logic              long_press,
    output logic              repeat_pulse,
    output logic [TICK_W-1:0] press_ticks,
    output logic              busy
);
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX  = '1;
    localparam logic [TICK_W-1:0] SHORT_LIM = TICK_W'(SHORT_MAX_TICKS);
    localparam logic [TICK_W-1:0] LONG_LIM  = TICK_W'(LONG_MIN_TICKS);
    localparam logic [RW-1:0]     RPT_LAST  = RW'(REPEAT_TICKS - 1);

    press_state_t      state_reg, state_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [RW-1:0]     rpt_cnt_reg, rpt_cnt_next;
    logic              short_reg, short_next;
    logic              mid_reg, mid_next;
    logic              long_reg, long_next;
    logic              repeat_reg, repeat_next;

    logic              tick;
    logic              press_ev;
    logic              release_ev;
    logic [TICK_W-1:0] tick_inc;

    assign press_ev   = pb_down & ~pb_up;
    // The level term recovers from a pb_up pulse that was never seen
    assign release_ev = pb_up | pb_state;
    assign tick_inc   = (tick_cnt_reg == TICK_MAX) ? tick_cnt_reg : tick_cnt_reg + 1'b1;

    // Held in clear while idle, so every press starts from a fresh tick phase
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg == ST_IDLE),
        .tick (tick)
    );

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        rpt_cnt_next  = rpt_cnt_reg;
        short_next    = 1'b0;
        mid_next      = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (press_ev) begin
                    state_next    = ST_PRESSED;
                    tick_cnt_next = '0;
                    rpt_cnt_next  = '0;
                end
            end
            ST_PRESSED: begin
                // A release in the same cycle as a tick drops that tick
                if (release_ev) begin
                    state_next = ST_IDLE;
                    if (tick_cnt_reg <= SHORT_LIM) begin
                        short_next = 1'b1;
                    end else begin
                        mid_next = 1'b1;
                    end
                end else if (tick) begin
                    tick_cnt_next = tick_inc;
                    if (tick_inc == LONG_LIM) begin
                        long_next    = 1'b1;
                        state_next   = ST_LONG_HELD;
                        rpt_cnt_next = '0;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (release_ev) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    tick_cnt_next = tick_inc;
                    if (rpt_cnt_reg == RPT_LAST) begin
                        rpt_cnt_next = '0;
                        repeat_next  = 1'b1;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            rpt_cnt_reg  <= '0;
            short_reg    <= 1'b0;
            mid_reg      <= 1'b0;
            long_reg     <= 1'b0;
            repeat_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            rpt_cnt_reg  <= rpt_cnt_next;
            short_reg    <= short_next;
            mid_reg      <= mid_next;
            long_reg     <= long_next;
            repeat_reg   <= repeat_next;
        end
    end

    // The tick counter only changes while busy, so it doubles as the frozen result
    assign press_ticks  = tick_cnt_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign short_press  = short_reg;
    assign mid_press    = mid_reg;
    assign long_press   = long_reg;
    assign repeat_pulse = repeat_reg;

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed bench for press_classifier with an analytic per-cycle
// model of tick timing, classification and auto-repeat.
module tb_press_classifier;

    localparam int TD    = 4;
    localparam int TW    = 4;
    localparam int SHORT = 3;
    localparam int LONG  = 12;
    localparam int REP   = 2;
    localparam int TMAX  = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pb_state = 1'b1;
    logic          pb_down = 1'b0;
    logic          pb_up = 1'b0;
    logic          short_press;
    logic          mid_press;
    logic          long_press;
    logic          repeat_pulse;
    logic [TW-1:0] press_ticks;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int last_pt  = 0;

    press_classifier #(
        .TICK_DIV        (TD),
        .TICK_W          (TW),
        .SHORT_MAX_TICKS (SHORT),
        .LONG_MIN_TICKS  (LONG),
        .REPEAT_TICKS    (REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_state     (pb_state),
        .pb_down      (pb_down),
        .pb_up        (pb_up),
        .short_press  (short_press),
        .mid_press    (mid_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .press_ticks  (press_ticks),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int bz, input int pt, input int sp,
                           input int mp, input int lp, input int rp);
        chk({tag, ".busy"},   {31'd0, busy},         bz);
        chk({tag, ".ticks"},  {28'd0, press_ticks},  pt);
        chk({tag, ".short"},  {31'd0, short_press},  sp);
        chk({tag, ".mid"},    {31'd0, mid_press},    mp);
        chk({tag, ".long"},   {31'd0, long_press},   lp);
        chk({tag, ".repeat"}, {31'd0, repeat_pulse}, rp);
    endtask

    function automatic int sat(input int v);
        return (v > TMAX) ? TMAX : v;
    endfunction

    // Expected outputs after busy edge i of a press whose release is sampled at edge k.
    // Ticks land on every TD-th edge after the press; the release edge's tick is lost.
    task automatic chk_press_cycle(input int i, input int k);
        int t, c;
        string tag;
        tag = $sformatf("press k=%0d i=%0d", k, i);
        if (i < k) begin
            t = i / TD;
            chk_all(tag, 1, sat(t), 0, 0,
                    int'((i % TD == 0) && (t == LONG)),
                    int'((i % TD == 0) && (t > LONG) && ((t - LONG) % REP == 0)));
        end else begin
            c = (k - 1) / TD;
            chk_all(tag, 0, sat(c), int'(c <= SHORT),
                    int'((c > SHORT) && (c < LONG)), 0, 0);
        end
    endtask

    // Press, hold until the release is sampled on busy edge k, then one idle cycle
    task automatic do_press(input int k, input bit level_only);
        $display("press: release at edge %0d level_only=%0d", k, level_only);
        pb_down  = 1'b1;
        pb_state = 1'b0;
        step();
        chk_press_cycle(0, k);
        pb_down = 1'b0;
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                pb_state = 1'b1;
                pb_up    = ~level_only;
            end
            step();
            pb_up = 1'b0;
            chk_press_cycle(i, k);
        end
        last_pt = sat((k - 1) / TD);
        step();
        chk_all($sformatf("post k=%0d", k), 0, last_pt, 0, 0, 0, 0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk_all($sformatf("%s c=%0d", tag, i), 0, last_pt, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int k;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle_cycles(2, "after_reset");

        do_press(10, 1'b0);   // 2 ticks: short
        idle_cycles(2, "gap");
        do_press(30, 1'b0);   // 7 ticks: mid
        idle_cycles(2, "gap");
        do_press(65, 1'b0);   // 16 ticks: long, repeats at 14 and 16, saturates at 15
        idle_cycles(2, "gap");
        do_press(48, 1'b0);   // release on the 12th tick: mid at 11
        idle_cycles(2, "gap");
        do_press(1, 1'b0);    // zero ticks: short
        idle_cycles(2, "gap");
        do_press(20, 1'b1);   // release via level only
        idle_cycles(2, "gap");

        for (int n = 0; n < 10; n++) begin
            k = $urandom_range(1, 80);
            do_press(k, 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(1, 4), "rgap");
        end

        // Reset at tick 5 while held: outputs clear without waiting for a clock
        $display("reset mid-press");
        pb_down  = 1'b1;
        pb_state = 1'b0;
        step();
        pb_down = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            step();
        end
        chk("pre_rst.ticks", {28'd0, press_ticks}, 5);
        #2 rst = 1'b1;
        #1;
        last_pt = 0;
        chk_all("rst_async", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        idle_cycles(20, "held_no_down");
        pb_state = 1'b1;
        idle_cycles(2, "released_idle");

        $display("glitch: lone pb_up");
        pb_up = 1'b1;
        step();
        pb_up = 1'b0;
        chk_all("lone_up", 0, 0, 0, 0, 0, 0);
        idle_cycles(3, "lone_up_after");

        $display("glitch: pb_down with pb_up");
        pb_down = 1'b1;
        pb_up   = 1'b1;
        step();
        pb_down = 1'b0;
        pb_up   = 1'b0;
        chk_all("down_up", 0, 0, 0, 0, 0, 0);
        idle_cycles(3, "down_up_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Consumes the debounced button outputs (pb_state, pb_down, pb_up) and times how long each press lasts, in prescaled ticks.
- Classifies each press as short, mid or long, and emits auto-repeat pulses while a long press is held.
- Sits directly downstream of the debouncer. Feeds the binary counter and LED logic with clean one-cycle event pulses, so those no longer decode tick values themselves.

Parameters:
- TICK_DIV, 2_500_000: clk cycles per duration tick (100 ms at 25 MHz); must be >= 2.
- TICK_W, 4: width of the press tick counter; it saturates at 2^TICK_W-1.
- SHORT_MAX_TICKS, 3: a release with count <= this is a short press.
- LONG_MIN_TICKS, 12: reaching this count while held is a long press; must be > SHORT_MAX_TICKS and < 2^TICK_W.
- REPEAT_TICKS, 2: ticks between repeat pulses in LONG_HELD; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pb_state  in  1  debounced level; 1 = button open/released, 0 = pressed
- pb_down  in  1  one-cycle pulse on debounced press
- pb_up  in  1  one-cycle pulse on debounced release
- short_press  out  1  one-cycle pulse on release of a short press
- mid_press  out  1  one-cycle pulse on release with SHORT_MAX_TICKS < count < LONG_MIN_TICKS
- long_press  out  1  one-cycle pulse when the count reaches LONG_MIN_TICKS while held
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TICKS ticks in LONG_HELD
- press_ticks  out  TICK_W  live tick count during a press; holds the final value after release
- busy  out  1  high in PRESSED or LONG_HELD

Behaviour:
- Reset:
  - State is IDLE.
  - Prescaler, tick counter, repeat counter and press_ticks are 0.
  - All pulse outputs and busy are 0.
- Events:
  - press_ev = pb_down & ~pb_up.
  - release_ev = pb_up | pb_state. The level term covers a missed pb_up.
- Registered outputs: all outputs are registered and are valid the cycle after the event that causes them.
- IDLE:
  - On press_ev: go to PRESSED; clear prescaler, tick counter and repeat counter; press_ticks becomes 0.
  - pb_up and pb_state alone are ignored.
- PRESSED:
  - The prescaler counts 0..TICK_DIV-1. A tick fires on the wrap, then the tick counter increments, saturating at 2^TICK_W-1.
  - When the tick counter becomes LONG_MIN_TICKS: long_press pulses in the same cycle the counter updates, and the state goes to LONG_HELD with the repeat counter at 0.
  - On release_ev: classify using the count held before this cycle, then go to IDLE.
    - count <= SHORT_MAX_TICKS: short_press.
    - Otherwise: mid_press.
  - A press released at 0 ticks is a short press.
  - pb_down while in PRESSED is ignored.
- LONG_HELD:
  - The tick counter keeps counting and saturating.
  - Each tick increments the repeat counter. When it reaches REPEAT_TICKS, repeat_pulse fires and the repeat counter clears.
  - On release_ev: go to IDLE with no classification pulse.
- Simultaneous events:
  - Release and tick in the same cycle: release wins, and the tick is discarded (no increment, no long_press, no repeat).
  - pb_down and pb_up in the same cycle while in IDLE: treated as a glitch, stays in IDLE.
- Pulse exclusivity: at most one of short_press, mid_press or long_press per cycle. Exactly one of them occurs per press.
- press_ticks mirrors the tick counter while busy and freezes on leaving to IDLE.
- Reset mid-press: the FSM returns to IDLE asynchronously and no pulse is emitted. After reset release, a new press requires a fresh pb_down.

Decomposition:
- Shared package (button_pkg): state encoding (IDLE, PRESSED, LONG_HELD) and default tick constants. The debouncer and counter blocks reuse the same constants.
- One natural sub-module: tick_prescaler. It is a TICK_DIV divider with a synchronous clear input and a tick pulse output, and is reusable by the LED blinkers.

Test Plan (TICK_DIV=4 for simulation):
- Press then release after 2 ticks (10 clk) -> short_press one pulse; press_ticks=2; busy drops the cycle after release.
- Press then release after 7 ticks -> mid_press one pulse; no short_press or long_press; press_ticks=7.
- Hold for 16 ticks -> long_press at tick 12; repeat_pulse at ticks 14 and 16; release gives no further pulse; press_ticks=15 (saturated).
- Release coinciding with the 12th tick wrap -> mid_press (count 11); no long_press.
- Assert rst at tick 5 while pressed -> all outputs 0 immediately; holding the button with no new pb_down produces no events.
- pb_up with no prior pb_down, and pb_down+pb_up in the same cycle -> no outputs, stays IDLE.
